muldiv_ctrl: RTL and testbench

//  Sequencer between the EX stage and the iterative shift-add multiplier. Accepts MULT/MULTU/MTHI/MTLO

---
 rtl/muldiv_ctrl.sv | 103 ++++++++++
 tb/tb_muldiv_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the iterative multiplier: latches operands, drives the
// begin/end handshake, owns HI/LO and reports busy/done/timeout to the pipeline.
module muldiv_ctrl #(
  parameter int TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_err,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        mult_begin,
  output logic        mult_signed,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] product,
  input  logic        mult_end
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Handshake: a request is taken on a rising edge where req_valid & req_ready & ~flush;
  // the multiplier sees mult_begin held high for the whole operation and answers with a
  // mult_end cycle carrying product.
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          md_err_q;
  logic          accept;
  logic          is_mul;
  logic          timeout;
  logic          commit;

  assign req_ready  = (state_q == IDLE);
  assign md_busy    = (state_q == BUSY);
  assign mult_begin = (state_q == BUSY);
  assign md_done    = (state_q == DONE);
  assign md_err     = md_err_q;

  assign accept  = req_valid & req_ready & ~flush;
  assign is_mul  = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign timeout = (state_q == BUSY) & ~flush & ~mult_end & (cnt_q == CW'(TIMEOUT - 1));
  assign commit  = (state_q == BUSY) & mult_end & ~flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = BUSY;
      BUSY: begin
        // flush beats a coincident mult_end so a cancelled product never lands
        if (flush)        state_d = IDLE;
        else if (mult_end) state_d = DONE;
        else if (timeout)  state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      md_err_q    <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      mult_op1    <= '0;
      mult_op2    <= '0;
      mult_signed <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_err_q <= timeout;
      if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
      else                 cnt_q <= '0;
      if (accept) begin
        case (req_op)
          OP_MULT, OP_MULTU: begin
            mult_op1    <= req_a;
            mult_op2    <= req_b;
            mult_signed <= (req_op == OP_MULT);
          end
          OP_MTHI: hi_out <= req_a;
          OP_MTLO: lo_out <= req_a;
          default: ;
        endcase
      end
      if (commit) {hi_out, lo_out} <= product;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: stub multiplier, driver tasks, and a scoreboard
// monitor that checks HI/LO on every md_done / md_err pulse.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [1:0] K_DONE   = 2'd1;
  localparam logic [1:0] K_ERR    = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic [63:0] product = '0;
  logic        mult_end = 1'b0;
  logic        req_ready, md_busy, md_done, md_err, mult_begin, mult_signed;
  logic [31:0] hi_out, lo_out, mult_op1, mult_op2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [65:0] exp_q[$];

  int stub_lat = 4;
  bit stub_en  = 1'b1;
  int stub_cnt = 0;

  muldiv_ctrl #(.TIMEOUT(48)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .flush(flush), .md_busy(md_busy),
    .md_done(md_done), .md_err(md_err), .hi_out(hi_out), .lo_out(lo_out),
    .mult_begin(mult_begin), .mult_signed(mult_signed), .mult_op1(mult_op1),
    .mult_op2(mult_op2), .product(product), .mult_end(mult_end)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // stub multiplier: answers after stub_lat cycles of mult_begin
  always @(posedge clk) begin
    logic signed [63:0] sa, sb;
    #1;
    if (!mult_begin) begin
      stub_cnt = 0;
      mult_end = 1'b0;
    end else begin
      stub_cnt++;
      if (stub_en && stub_cnt == stub_lat) begin
        sa = {{32{mult_op1[31]}}, mult_op1};
        sb = {{32{mult_op2[31]}}, mult_op2};
        product  = mult_signed ? sa * sb : {32'b0, mult_op1} * {32'b0, mult_op2};
        mult_end = 1'b1;
      end else begin
        mult_end = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [65:0] e;
    if (!rst && (md_done || md_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {62'b0, md_err, md_done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind", {62'b0, md_err, md_done}, {62'b0, e[65:64]});
        check("sb_hilo", {hi_out, lo_out}, e[63:0]);
        if (md_done) check("done_begin_low", {63'b0, mult_begin}, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    check(name, {63'b0, ok}, 64'd1);
  endtask

  initial begin
    int busy_cnt;
    int gap;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {63'b0, req_ready}, 64'd1);
    check("rst_busy", {63'b0, md_busy}, 64'd0);
    check("rst_begin", {63'b0, mult_begin}, 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_ops", {mult_op1, mult_op2}, 64'd0);
    check("rst_flags", {60'b0, md_done, md_err, mult_signed, 1'b0}, 64'd0);
    rst = 1'b0;

    // 1: signed MULT
    stub_lat = 4;
    exp_q.push_back({K_DONE, 32'hFFFFFFFF, 32'hFFFFFFFA});
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    check("t1_signed", {63'b0, mult_signed}, 64'd1);
    check("t1_begin", {63'b0, mult_begin}, 64'd1);
    check("t1_ready", {63'b0, req_ready}, 64'd0);
    check("t1_ops", {mult_op1, mult_op2}, {32'hFFFFFFFE, 32'd3});
    wait_idle("t1_idle");

    // 2: unsigned MULTU, busy spans accept to mult_end edge
    stub_lat = 6;
    exp_q.push_back({K_DONE, 32'hFFFFFFFE, 32'h00000001});
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) check("t2_unsigned", {63'b0, mult_signed}, 64'd0);
      if (md_busy) busy_cnt++;
      else break;
    end
    check("t2_busy_cycles", busy_cnt, 64'd6);
    check("t2_done_after_busy", {63'b0, md_done}, 64'd1);
    wait_idle("t2_idle");

    // 3: MTHI then MTLO back to back
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h1234;
    @(posedge clk);
    #1 req_op = OP_MTLO; req_a = 32'h5678;
    @(negedge clk);
    check("t3_hi", {32'b0, hi_out}, 64'h1234);
    check("t3_lo_prev", {32'b0, lo_out}, 64'h1);
    check("t3_begin0", {63'b0, mult_begin}, 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("t3_lo", {32'b0, lo_out}, 64'h5678);
    check("t3_hi_keep", {32'b0, hi_out}, 64'h1234);
    check("t3_begin1", {63'b0, mult_begin | md_busy}, 64'd0);

    // 4: MULT 5*0 then MULT 7*6 held valid; gap is the DONE cycle plus the accepting IDLE cycle
    stub_lat = 2;
    exp_q.push_back({K_DONE, 32'd0, 32'd0});
    exp_q.push_back({K_DONE, 32'd0, 32'd42});
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd5; req_b = 32'd0;
    @(posedge clk);
    #1 req_a = 32'd7; req_b = 32'd6;
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mult_begin) gap++;
      else if (gap > 0) break;
      if (req_ready && req_valid) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    check("t4_begin_gap", gap, 64'd2);
    check("t4_ops2", {mult_op1, mult_op2}, {32'd7, 32'd6});
    wait_idle("t4_idle");

    // 5: flush mid-MULTU leaves HI/LO alone
    issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
    issue(OP_MTLO, 32'hA5A5A5A5, 32'd0);
    stub_lat = 30;
    issue(OP_MULTU, 32'h10000, 32'h10000);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("t5_ready", {63'b0, req_ready}, 64'd1);
    check("t5_busy", {63'b0, md_busy}, 64'd0);
    check("t5_hilo", {hi_out, lo_out}, 64'hA5A5A5A5_A5A5A5A5);
    repeat (40) @(negedge clk);
    check("t5_hilo_late", {hi_out, lo_out}, 64'hA5A5A5A5_A5A5A5A5);

    // 6: timeout after 48 busy cycles, then async reset mid-BUSY
    stub_en = 1'b0;
    exp_q.push_back({K_ERR, 32'hA5A5A5A5, 32'hA5A5A5A5});
    issue(OP_MULT, 32'h01234567, 32'h89ABCDEF);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (md_err) break;
      if (md_busy) busy_cnt++;
    end
    check("t6_busy_cycles", busy_cnt, 64'd48);
    check("t6_err", {63'b0, md_err}, 64'd1);
    check("t6_idle", {63'b0, req_ready}, 64'd1);
    @(negedge clk);
    check("t6_err_pulse", {63'b0, md_err}, 64'd0);

    issue(OP_MULT, 32'h01234567, 32'h89ABCDEF);
    repeat (5) @(negedge clk);
    check("t6_busy_before_rst", {63'b0, md_busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_begin", {63'b0, mult_begin}, 64'd0);
    check("t6_rst_hilo", {hi_out, lo_out}, 64'd0);
    check("t6_rst_ops", {mult_op1, mult_op2}, 64'd0);
    check("t6_rst_flags", {59'b0, md_busy, md_done, md_err, mult_signed, ~req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stub_en = 1'b1;
    repeat (3) @(negedge clk);

    // final report
    check("sb_drained", exp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
